// File: rtl/des_io_pkg.sv
// des_io_pkg
//   Shared definitions for the DES result output path: streamer state
//   encoding, ASCII constants and the default digit count.
//   Configuration macro used by the streamer: HEX_GROUP_SPACE_EN.
package des_io_pkg;

  // Default number of hex digits per DES result word
  localparam int NDIGITS_DEF = 16;

  // ASCII constants
  localparam logic [7:0] ZERO    = 8'h30;
  localparam logic [7:0] UPPER_A = 8'h41;
  localparam logic [7:0] LOWER_A = 8'h61;
  localparam logic [7:0] SPACE   = 8'h20;

  // Streamer state encoding (4-bit codes; unused codes recover to IDLE)
  localparam logic [3:0] ST_IDLE_ENC = 4'd0;
  localparam logic [3:0] ST_LOAD_ENC = 4'd1;
  localparam logic [3:0] ST_SEND_ENC = 4'd2;
  localparam logic [3:0] ST_FIN_ENC  = 4'd3;

  typedef enum logic [3:0] {
    S_IDLE = ST_IDLE_ENC,
    S_LOAD = ST_LOAD_ENC,
    S_SEND = ST_SEND_ENC,
    S_FIN  = ST_FIN_ENC
  } state_t;

endpackage

// File: rtl/nibble_to_ascii.sv
// nibble_to_ascii
//   Combinational conversion of one 4-bit value to its ASCII hex character.
// Parameters
//   UPPERCASE : 1 -> 'A'..'F', 0 -> 'a'..'f'
// Ports
//   nibble in  4  value to convert
//   ascii  out 8  ASCII character
module nibble_to_ascii
  import des_io_pkg::*;
#(
  parameter bit UPPERCASE = 1'b1
) (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // Map 0..9 onto '0'..'9' and 10..15 onto the selected letter range
  always_comb begin
    ascii = ZERO;
    if (nibble < 4'd10) begin
      ascii = ZERO + {4'd0, nibble};
    end else if (UPPERCASE) begin
      ascii = UPPER_A + {4'd0, nibble} - 8'd10;
    end else begin
      ascii = LOWER_A + {4'd0, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/hex_result_streamer.sv
// hex_result_streamer
//   Captures a DES result word and streams it as ASCII hex characters,
//   most significant nibble first, over a valid/ready character interface.
//   nSent tracks digits accepted by the sink for cursor positioning.
// Configuration
//   HEX_GROUP_SPACE_EN : when defined, an ASCII space is inserted after
//                        digits 4, 8 and 12 (19 characters per word).
// Parameters
//   NDIGITS   : hex digits per word (data width 4*NDIGITS)
//   UPPERCASE : letter case of digits A..F
// Ports
//   clk        in  1          clock, rising edge
//   rst        in  1          asynchronous active-low reset
//   values     in  4*NDIGITS  word to stream, sampled on accepted start
//   start      in  1          stream request, honoured only when idle
//   busy       out 1          high from capture until done
//   char_out   out 8          ASCII character
//   char_valid out 1          char_out is valid
//   char_ready in  1          sink accepts on valid & ready
//   nSent      out 5          hex digits accepted so far
//   done       out 1          one-cycle pulse after the final character
module hex_result_streamer
  import des_io_pkg::*;
#(
  parameter int NDIGITS   = NDIGITS_DEF,
  parameter bit UPPERCASE = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4*NDIGITS-1:0] values,
  input  logic                 start,
  output logic                 busy,
  output logic [7:0]           char_out,
  output logic                 char_valid,
  input  logic                 char_ready,
  output logic [4:0]           nSent,
  output logic                 done
);

  localparam int         W        = 4 * NDIGITS;
  localparam logic [4:0] LAST_IDX = 5'(NDIGITS - 1);

  state_t         state_r, state_nx;
  logic [W-1:0]   shadow_r, shadow_nx;
  logic [4:0]     nsent_r, nsent_nx;
  logic [7:0]     char_r, char_nx;
  logic           valid_r, valid_nx;
  logic           busy_r, busy_nx;
  logic           done_r, done_nx;
  // High while the character in flight is a group separator
  logic           space_r, space_nx;

  logic [7:0]     digit_ascii_s;
  logic [4:0]     next_count_s;
  logic           space_due_s;

  nibble_to_ascii #(
    .UPPERCASE(UPPERCASE)
  ) u_nibble_to_ascii (
    .nibble(shadow_r[W-1 -: 4]),
    .ascii (digit_ascii_s)
  );

  assign next_count_s = nsent_r + 5'd1;

`ifdef HEX_GROUP_SPACE_EN
  // A separator follows every fourth digit except the last one
  assign space_due_s = (next_count_s[1:0] == 2'b00);
`else
  assign space_due_s = 1'b0;
`endif

  // Next-state and next-output computation for the streaming FSM
  always_comb begin
    state_nx  = state_r;
    shadow_nx = shadow_r;
    nsent_nx  = nsent_r;
    char_nx   = char_r;
    valid_nx  = valid_r;
    busy_nx   = busy_r;
    done_nx   = 1'b0;
    space_nx  = space_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          shadow_nx = values;
          nsent_nx  = 5'd0;
          busy_nx   = 1'b1;
          space_nx  = 1'b0;
          state_nx  = S_LOAD;
        end else begin
          state_nx  = S_IDLE;
        end
      end
      S_LOAD: begin
        if (space_r) begin
          char_nx = SPACE;
        end else begin
          char_nx = digit_ascii_s;
        end
        valid_nx = 1'b1;
        state_nx = S_SEND;
      end
      S_SEND: begin
        if (valid_r && char_ready) begin
          valid_nx = 1'b0;
          if (space_r) begin
            // Separator accepted: the pending digit is still at the top
            space_nx = 1'b0;
            state_nx = S_LOAD;
          end else begin
            shadow_nx = {shadow_r[W-5:0], 4'h0};
            nsent_nx  = next_count_s;
            if (nsent_r == LAST_IDX) begin
              state_nx = S_FIN;
            end else begin
              space_nx = space_due_s;
              state_nx = S_LOAD;
            end
          end
        end else begin
          state_nx = S_SEND;
        end
      end
      S_FIN: begin
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        state_nx = S_IDLE;
      end
      default: begin
        valid_nx = 1'b0;
        busy_nx  = 1'b0;
        space_nx = 1'b0;
        state_nx = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any stream in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= S_IDLE;
      shadow_r <= '0;
      nsent_r  <= 5'd0;
      char_r   <= 8'h00;
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      space_r  <= 1'b0;
    end else begin
      state_r  <= state_nx;
      shadow_r <= shadow_nx;
      nsent_r  <= nsent_nx;
      char_r   <= char_nx;
      valid_r  <= valid_nx;
      busy_r   <= busy_nx;
      done_r   <= done_nx;
      space_r  <= space_nx;
    end
  end

  assign busy       = busy_r;
  assign char_out   = char_r;
  assign char_valid = valid_r;
  assign nSent      = nsent_r;
  assign done       = done_r;

endmodule
